// File: rtl/rf_writeback_arbiter_pkg.sv
// Constants shared between the register file and its write-side arbiter.
package rf_writeback_arbiter_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_AW   = 5;
  localparam int RF_X0   = 0;
endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// Circular buffer of pending load results {live, rd, data} with kill-by-rd and two rd lookups.
module wb_fifo
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [AW-1:0]   push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            kill,
  input  logic [AW-1:0]   kill_rd,
  output logic            head_live,
  output logic [AW-1:0]   head_rd,
  output logic [XLEN-1:0] head_data,
  output logic [CW-1:0]   count,
  input  logic [AW-1:0]   look1,
  input  logic [AW-1:0]   look2,
  output logic            hit1,
  output logic            hit2
);

  logic [DEPTH-1:0] live;
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  // A slot is cleared on pop, so a set live bit always implies an occupied slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && live[i] && (rd_q[i] == kill_rd)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rptr] <= 1'b0;
        rptr       <= rptr + 1'b1;
      end
      if (push) begin
        live[wptr] <= 1'b1;
        wptr       <= wptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= push_rd;
      data_q[wptr] <= push_data;
    end
  end

  assign head_live = live[rptr];
  assign head_rd   = rd_q[rptr];
  assign head_data = data_q[rptr];

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (rd_q[i] == look1)) hit1 = 1'b1;
      if (live[i] && (rd_q[i] == look2)) hit2 = 1'b1;
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register file write-port arbiter: ALU results vs buffered LSU loads, x0 suppression,
// WAW kill of stale loads and pending-load hazard flags for decode.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            WE,
  output logic [AW-1:0]   A3,
  output logic [XLEN-1:0] WD3,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic            pend1,
  output logic            pend2
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] X0 = AW'(RF_X0);

  logic            full;
  logic            push;
  logic            pop;
  logic            alu_issue;
  logic            issue;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            head_live;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;
  logic [CW-1:0]   count;
  logic            hit1;
  logic            hit2;

  wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (pop),
    .kill      (alu_issue),
    .kill_rd   (alu_rd),
    .head_live (head_live),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count),
    .look1     (A1),
    .look2     (A2),
    .hit1      (hit1),
    .hit2      (hit2)
  );

  assign full      = (count == CW'(DEPTH));
  assign alu_ready = !full;
  assign lsu_ready = !full;
  assign pend1     = hit1 && (A1 != X0);
  assign pend2     = hit2 && (A2 != X0);

  // A full FIFO takes the port unconditionally so loads can never starve behind the ALU.
  always_comb begin
    alu_issue = 1'b0;
    pop       = 1'b0;
    issue     = 1'b0;
    wa        = head_rd;
    wd        = head_data;
    if (full) begin
      pop   = 1'b1;
      issue = head_live && (head_rd != X0);
    end else if (alu_valid && (alu_rd != X0)) begin
      alu_issue = 1'b1;
      issue     = 1'b1;
      wa        = alu_rd;
      wd        = alu_data;
    end else if (count != '0) begin
      pop   = 1'b1;
      issue = head_live && (head_rd != X0);
    end
  end

  // A load racing a same-rd ALU write is older, so it is accepted and dropped.
  assign push = lsu_valid && lsu_ready && (lsu_rd != X0) &&
                !(alu_issue && (lsu_rd == alu_rd));

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE  <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE <= issue;
      if (issue) begin
        A3  <= wa;
        WD3 <= wd;
      end
    end
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side front end of the 32x32 RISC-V register file: merges ALU results with multi-cycle load results from the LSU.
- Issues at most one write per cycle on the register file write port (WE/A3/WD3).
- Buffers LSU results in a small FIFO and suppresses writes to x0.
- Kills stale buffered loads overwritten by younger ALU writes, and reports pending-load hazards for decode-stage stall logic.

Parameters:
DEPTH, 4, LSU result FIFO entries (power of two, >=2)
XLEN, 32, data width
AW, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result valid this cycle
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  pipeline may advance an ALU result; 0 stalls the pipeline
lsu_valid  in  1  load result valid
lsu_rd  in  AW  load destination register
lsu_data  in  XLEN  load data
lsu_ready  out  1  FIFO can accept; transfer = lsu_valid & lsu_ready
WE  out  1  register file write enable (registered)
A3  out  AW  register file write address (registered)
WD3  out  XLEN  register file write data (registered)
A1  in  AW  decode read address 1 (hazard lookup)
A2  in  AW  decode read address 2 (hazard lookup)
pend1  out  1  live FIFO entry targets A1 (A1 != 0)
pend2  out  1  live FIFO entry targets A2 (A2 != 0)

Behaviour:
- Reset (async, rst_n=0): WE=0, A3=0, WD3=0, FIFO empty, all entry live bits cleared, read/write pointers=0. After reset, lsu_ready=1, alu_ready=1, pend1=pend2=0.
- Outputs WE/A3/WD3 are registered; write latency is 1 cycle from the accepted result. The register file commits on the following edge.
- Write select each cycle, highest priority first:
  - FIFO full (count==DEPTH): alu_ready=0. Drain the FIFO head; the ALU input is ignored.
  - Otherwise, alu_valid & alu_ready & alu_rd!=0: issue the ALU write.
  - Otherwise, FIFO non-empty: pop the head. Issue a write only if the head is live and its rd!=0.
  - Otherwise: WE=0. A3 and WD3 hold their previous values.
- alu_ready = (count != DEPTH), combinational from registered count.
- lsu_ready = (count != DEPTH), combinational.
- Enqueue and pop in the same cycle are allowed. Count is unchanged by such a cycle.
- x0 handling:
  - An accepted ALU result with rd==0 is consumed and produces no write.
  - An LSU result with rd==0 is accepted by the handshake but not enqueued.
- WAW kill:
  - An issued ALU write to rd R clears the live bit of every FIFO entry with rd==R.
  - An LSU result with rd==R accepted in the same cycle is treated as older. It is accepted but not enqueued.
  - A popped dead entry consumes the drain slot and produces WE=0.
- pend1/pend2 are combinational. They OR over live, occupied entries only; the in-flight output register is excluded. The decode stage bypasses from WE/A3/WD3.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- Reset asserted mid-operation discards all buffered loads and any in-flight write. No partial write is issued.

Decomposition:
- Shared package: XLEN and AW constants, and the X0 index constant, so rf_riscv and this block agree.
- One natural sub-module: wb_fifo. It is a DEPTH-entry circular buffer of {live, rd, data} and provides:
  - push and pop
  - a per-entry kill-by-rd port
  - two rd-match lookup ports
- This block contains only the priority select and the output register.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> WE=0, A3=0, WD3=0, lsu_ready=1, alu_ready=1, pend1=pend2=0. Release rst_n -> no WE pulse.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle WE=1, A3=5, WD3=0xDEADBEEF. alu rd=0 -> WE stays 0.
- LSU drain: enqueue loads rd=3 (0x11) and rd=4 (0x22) while ALU writes rd=7 each cycle -> ALU writes first, then rd=3, then rd=4 in FIFO order. pend1=1 with A1=3 until rd=3 pops.
- Full/backpressure: enqueue 4 loads with no drain slot available -> lsu_ready=0 and alu_ready=0. The next cycle drains the head, and both readies return to 1 the cycle after.
- WAW kill: load rd=9 (0xAA) queued, then ALU writes rd=9 (0xBB) -> WE A3=9 WD3=0xBB. The later pop of the dead entry gives WE=0, and the RF holds 0xBB. Same-cycle LSU rd=9 with ALU rd=9 -> only the ALU write occurs.
- Reset mid-run: FIFO holding 3 entries, pull rst_n low -> all pend outputs 0, count 0, and no writes after release.
